// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and frame helpers for the dual-ADC SPI capture path.
// Frame layout: 4 leading zero bits followed by 12 data bits, MSB first.
package adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int DATA_BITS  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } adc_state_e;

  // True when any of the leading bits (which the ADC should drive as zero) is set.
  function automatic logic lead_set(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1 -: LEAD_BITS];
  endfunction

  function automatic logic [DATA_BITS-1:0] frame_data(input logic [FRAME_BITS-1:0] frame);
    return frame[DATA_BITS-1:0];
  endfunction

endpackage

// File: rtl/adc_if.sv
// Start/serial/sample bundle between the sampling timer, the ADC pins and the DSP datapath.
// master = capture block, slave = its environment (timer, ADC pair, sample consumer).
interface adc_if;
  import adc_pkg::*;

  logic                 start;
  logic                 miso1;
  logic                 miso2;
  logic                 csn;
  logic                 sclk;
  logic [DATA_BITS-1:0] dout1;
  logic [DATA_BITS-1:0] dout2;
  logic                 valid;
  logic                 busy;
  logic                 lead_err;

  modport master (
    input  start, miso1, miso2,
    output csn, sclk, dout1, dout2, valid, busy, lead_err
  );

  modport slave (
    output start, miso1, miso2,
    input  csn, sclk, dout1, dout2, valid, busy, lead_err
  );

endinterface

// File: rtl/adc_shreg.sv
// MSB-first serial-in shift register with parallel output; one per ADC data line.
// Shifts only on shift_en, so the frame content holds after the last bit.
module adc_shreg
  import adc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] q
);

  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {sr_q[FRAME_BITS-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/adc_rx.sv
// Dual AD7476A-class capture: one start pulse runs a 16-bit SPI frame on both data lines
// and publishes two 12-bit samples with a one-cycle valid strobe; all outputs registered.
module adc_rx
  import adc_pkg::*;
#(
  parameter int SCLK_HALF = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic   clk,
  input  logic   rst,
  adc_if.master  bus
);

  // Setup half-period plus 16 full SCLK periods.
  localparam int CONV_CYC = 33 * SCLK_HALF;
  localparam int CNT_MAX  = (CONV_CYC > QUIET_CYC) ? CONV_CYC : QUIET_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int HC_W     = $clog2(SCLK_HALF);

  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
  localparam logic [HC_W-1:0]  HALF_LAST  = HC_W'(SCLK_HALF - 1);

  adc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HC_W-1:0]      hc_q, hc_d;
  logic                 csn_q, csn_d;
  logic                 sclk_q, sclk_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 lead_err_q, lead_err_d;
  logic [DATA_BITS-1:0] dout1_q, dout1_d;
  logic [DATA_BITS-1:0] dout2_q, dout2_d;

  logic                  shift_en;
  logic [FRAME_BITS-1:0] sh1;
  logic [FRAME_BITS-1:0] sh2;

  // Sample on the edge where SCLK falls; the falling transition at the frame end is excluded
  // because SCLK is forced high there instead of toggling.
  assign shift_en = (state_q == CONV) && sclk_q && (hc_q == HALF_LAST) && (cnt_q != CONV_LAST);

  adc_shreg u_sh1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (bus.miso1),
    .q        (sh1)
  );

  adc_shreg u_sh2 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (bus.miso2),
    .q        (sh2)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hc_d       = hc_q;
    csn_d      = csn_q;
    sclk_d     = sclk_q;
    dout1_d    = dout1_q;
    dout2_d    = dout2_q;
    valid_d    = 1'b0;
    lead_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CONV;
          cnt_d   = '0;
          hc_d    = '0;
          csn_d   = 1'b0;
          sclk_d  = 1'b1;
        end
      end

      CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d    = QUIET;
          cnt_d      = '0;
          hc_d       = '0;
          csn_d      = 1'b1;
          sclk_d     = 1'b1;
          dout1_d    = frame_data(sh1);
          dout2_d    = frame_data(sh2);
          valid_d    = 1'b1;
          lead_err_d = lead_set(sh1) | lead_set(sh2);
        end else begin
          cnt_d = cnt_q + 1'b1;
          // SCLK toggles at every half-period boundary after the setup half.
          if (hc_q == HALF_LAST) begin
            hc_d   = '0;
            sclk_d = ~sclk_q;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end

      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hc_d    = '0;
        csn_d   = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hc_q       <= '0;
      csn_q      <= 1'b1;
      sclk_q     <= 1'b1;
      dout1_q    <= '0;
      dout2_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      lead_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hc_q       <= hc_d;
      csn_q      <= csn_d;
      sclk_q     <= sclk_d;
      dout1_q    <= dout1_d;
      dout2_q    <= dout2_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      lead_err_q <= lead_err_d;
    end
  end

  assign bus.csn      = csn_q;
  assign bus.sclk     = sclk_q;
  assign bus.dout1    = dout1_q;
  assign bus.dout2    = dout2_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.lead_err = lead_err_q;

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: behavioural ADC pair driving MSB-first words, and a frame-level model
// predicting samples, lead flag and strobe time for every accepted start.
module tb_adc_rx;

  localparam int H      = 4;
  localparam int QC     = 8;
  localparam int LAT    = 33 * H + 1;
  localparam int PERIOD = 1 + 33 * H + QC;

  typedef struct {
    logic [15:0] w1;
    logic [15:0] w2;
    int          vcyc;
  } exp_t;

  logic clk;
  logic rst;
  adc_if bus ();

  adc_rx #(.SCLK_HALF(H), .QUIET_CYC(QC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [15:0] adc_w1 = 16'h0;
  logic [15:0] adc_w2 = 16'h0;
  int   n_pushed = 0;
  int   n_valid = 0;
  int   csn_fall_cyc = 0;
  int   csn_rise_cyc = 0;
  int   sclk_idle_bad = 0;
  bit   abort = 0;
  bit   b2b_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge: start is sampled at the next rising edge (frame cycle 0).
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] w1, input logic [15:0] w2, input bit push,
                             output int n);
    exp_t e;
    n = cyc;
    adc_w1 = w1;
    adc_w2 = w2;
    if (push) begin
      e.w1 = w1;
      e.w2 = w2;
      e.vcyc = n + LAT;
      exp_q.push_back(e);
      n_pushed++;
    end
    pulse_start();
  endtask

  // ADC pair: bit 15 appears after CSN falls, each SCLK fall advances one bit.
  initial begin
    int nf;
    nf = 0;
    forever begin
      @(negedge bus.csn or negedge bus.sclk);
      if (!bus.csn) begin
        if (bus.sclk) nf = 0;
        else nf++;
        #1;
        if (nf < 16) begin
          bus.miso1 = adc_w1[15-nf];
          bus.miso2 = adc_w2[15-nf];
        end
      end
    end
  end

  // Pin-level monitor sampled mid-cycle.
  initial begin
    logic prev_csn, prev_sclk;
    int   falls;
    exp_t e;
    prev_csn = 1'b1;
    prev_sclk = 1'b1;
    falls = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.csn && !bus.sclk) sclk_idle_bad++;
        if (!bus.csn && prev_csn) begin
          csn_fall_cyc = cyc;
          falls = 0;
          // QUIET cycles plus the IDLE cycle that samples the next start.
          if (b2b_chk) check("quiet_gap", cyc - csn_rise_cyc, QC + 1);
        end
        if (bus.csn && !prev_csn) begin
          csn_rise_cyc = cyc;
          if (!abort) check("csn_low_len", cyc - csn_fall_cyc, 33 * H);
        end
        if (!bus.sclk && prev_sclk && !bus.csn) begin
          if (falls == 0) check("setup_len", cyc - csn_fall_cyc, H);
          falls++;
        end
        if (bus.valid) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("dout1", bus.dout1, e.w1[11:0]);
            check("dout2", bus.dout2, e.w2[11:0]);
            check("lead_err", bus.lead_err, (e.w1[15:12] != 0 || e.w2[15:12] != 0));
            check("valid_cyc", cyc, e.vcyc);
            check("sclk_falls", falls, 16);
          end
        end
        prev_csn = bus.csn;
        prev_sclk = bus.sclk;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int n, n2;
    logic [15:0] w1, w2;
    rst = 1'b0;
    bus.start = 1'b0;
    #1 rst = 1'b1;
    #10;
    check("rst_csn", bus.csn, 1);
    check("rst_sclk", bus.sclk, 1);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dout1", bus.dout1, 0);
    check("rst_dout2", bus.dout2, 0);
    check("rst_lead", bus.lead_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame
    start_frame(16'h0ABC, 16'h0123, 1, n);
    wait_until(n + 3);
    check("busy_conv", bus.busy, 1);
    check("csn_conv", bus.csn, 0);
    wait_until(n + PERIOD);
    check("busy_idle", bus.busy, 0);

    // Extremes, then a leading-bit error followed by a clean frame
    start_frame(16'h0FFF, 16'h0000, 1, n);
    wait_until(n + PERIOD);
    start_frame(16'h0000, 16'h0FFF, 1, n);
    wait_until(n + PERIOD);
    start_frame(16'h0ABC, 16'h8555, 1, n);
    wait_until(n + PERIOD);
    start_frame(16'h0456, 16'h0789, 1, n);
    wait_until(n + PERIOD + 5);

    // Starts at 50 and 135 fall in CONV/QUIET and are dropped; 141 is the first IDLE cycle
    start_frame(16'h0321, 16'h0CDE, 1, n);
    wait_until(n + 50);
    pulse_start();
    wait_until(n + 135);
    pulse_start();
    wait_until(n + PERIOD);
    start_frame(16'h0111, 16'h0222, 1, n2);
    wait_until(n + 145);
    check("restart_csn_fall", csn_fall_cyc - n, PERIOD + 1);
    wait_until(n2 + PERIOD + 3);

    // Asynchronous reset mid-frame
    abort = 1;
    start_frame(16'h0F0F, 16'h00F0, 0, n);
    wait_until(n + 60);
    #2 rst = 1'b1;
    #1;
    check("abort_csn", bus.csn, 1);
    check("abort_sclk", bus.sclk, 1);
    check("abort_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_dout1", bus.dout1, 0);
    check("abort_dout2", bus.dout2, 0);
    abort = 0;
    start_frame(16'h0A5A, 16'h05A5, 1, n);
    wait_until(n + PERIOD + 2);

    // Random words, random gaps, random ignored starts while busy
    for (int i = 0; i < 20; i++) begin
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w1[15:12] = 4'h0;
      if ($urandom_range(0, 3) != 0) w2[15:12] = 4'h0;
      start_frame(w1, w2, 1, n);
      if ($urandom_range(0, 1) == 1) begin
        wait_until(n + $urandom_range(1, PERIOD - 1));
        pulse_start();
      end
      wait_until(n + PERIOD + $urandom_range(0, 20));
    end

    // Back-to-back at the fastest start-to-start period
    for (int i = 0; i < 100; i++) begin
      b2b_chk = (i > 0);
      start_frame({4'h0, 12'(i * 41)}, {4'h0, 12'(i)}, 1, n);
      wait_until(n + PERIOD);
    end
    wait_until(n + PERIOD + 10);
    b2b_chk = 0;

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("valid_count", n_valid, n_pushed);
    check("sclk_idle_high", sclk_idle_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
